alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, clocked successor to the board-level 4-bit combinational ALU. Width is WIDTH bits.
//  Adds 16 opcodes, registered results, and a full Z/C/V/N flag set. ADC/SBB chain through a stored carry.
//  MULU and DIVU are multi-cycle, with a valid/ready handshake on both sides.
//  Sits between switch/button input logic and LED/7-seg display logic.
// PARAMETERS
//  WIDTH        8  operand/result width (>=4)
//  ACTIVE_LOW_IO 0 1: invert a, b, opcode at input and result, result_hi, flags at output (board pins)
// PORTS
//  clk        in  1      single clock, rising edge
//  rst_n      in  1      asynchronous, active-low reset
//  in_valid   in  1      operands/opcode valid
//  in_ready   out 1      block accepts a command (high only in IDLE)
//  a, b       in  WIDTH  operands
//  opcode     in  4      see table
//  out_valid  out 1      result/flags valid; held until out_ready
//  out_ready  in  1      consumer takes result
//  result     out WIDTH  primary result (low product / quotient)
//  result_hi  out WIDTH  high product / remainder; 0 for other ops
//  flag_z/c/v/n out 1    zero, carry/borrow, signed overflow, sign(result MSB)
//  div_zero   out 1      DIVU with b==0
// BEHAVIOUR
//  Opcodes:
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL1, 7 SHR1 (logical)
//   8 ADC (a+b+Cst), 9 SBB (a-b-Cst), A SRA1, B ROL1, C MULU, D DIVU, E CMP (flags of a-b, result=a), F PASS b
//  FSM IDLE->CALC->DONE->IDLE. Accept when in_valid&&in_ready. Operands and opcode are latched at acceptance.
//  Single-cycle ops (incl. DIVU b==0): IDLE->DONE; out_valid rises the cycle after accept (latency 1).
//  MULU: shift-and-add over WIDTH CALC cycles. DIVU: restoring divide over WIDTH CALC cycles.
//   Both have out_valid at exactly WIDTH+1 cycles after accept.
//  DONE: outputs frozen while out_ready=0. On out_valid&&out_ready -> IDLE; in_ready is high the next cycle.
//   No back-to-back accept in the same cycle as the handoff.
//  in_valid outside IDLE is ignored; operand changes during CALC/DONE have no effect.
//  Width rules: ADD/ADC carry = bit WIDTH of a (WIDTH+1)-bit sum.
//   SUB/SBB/CMP: C=1 means borrow (a < b+Cin unsigned).
//   V is signed overflow for ADD/ADC/SUB/SBB/CMP, and 0 otherwise.
//   SHL1/ROL1: C = old a MSB. SHR1/SRA1: C = old a LSB. Logic ops, NOT, PASS, MULU, DIVU: C=0.
//  MULU: {result_hi,result} = a*b. Z/N are computed on result only; C = (result_hi != 0).
//  DIVU: result = a/b, result_hi = a%b.
//   b==0: result = all-ones, result_hi = a, div_zero=1, latency 1.
//   div_zero is cleared on the next accept.
//  Z = (result == 0). N = result[WIDTH-1].
//  Stored carry Cst: updated with flag_c on every completed op. ADC/SBB use the Cst value held at accept.
//  Reset (async, any state, incl. mid-CALC): state=IDLE, computation abandoned, Cst=0.
//   out_valid=0; result, result_hi, flags and div_zero = logical 0 (pins all-ones if ACTIVE_LOW_IO=1).
//   in_ready=1 from the first clock edge after rst_n deasserts.
//  Handshake signals are never inverted by ACTIVE_LOW_IO.
// TESTING (WIDTH=8, ACTIVE_LOW_IO=0)
//  ADD a=F0 b=20 -> result=10, C=1, V=0, Z=0, N=0; out_valid 1 cycle after accept.
//  SUB a=05 b=07 -> result=FE, C=1, N=1. Then SBB a=10 b=00 -> result=0F, C=0.
//  MULU a=0F b=11 -> result=FF, result_hi=00, C=0; out_valid exactly 9 cycles after accept.
//   in_ready=0 throughout the operation.
//  DIVU a=64 b=07 -> result=0E, result_hi=02.
//   DIVU a=2A b=00 -> result=FF, result_hi=2A, div_zero=1, latency 1.
//  Backpressure: hold out_ready=0 5 cycles with in_valid=1 and changing a/b -> outputs stable, in_ready=0.
//   Nothing is accepted; after out_ready=1, next command accepted 1 cycle later.
//  Assert rst_n=0 at MULU CALC cycle 4 -> outputs 0 and out_valid=0 immediately.
//   After release, ADC a=01 b=01 -> result=02 (Cst cleared).

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: clocked WIDTH-bit ALU with 16 opcodes, Z/C/V/N flags, a stored carry for ADC/SBB,
// and multi-cycle MULU/DIVU, with valid/ready handshakes on the command and result sides.
module alu_seq #(
   parameter int WIDTH         = 8,
   parameter bit ACTIVE_LOW_IO = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_n,
   output logic             div_zero
);

   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4, OP_NOT  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7;
   localparam logic [3:0] OP_ADC  = 4'h8, OP_SBB  = 4'h9, OP_SRA  = 4'hA, OP_ROL  = 4'hB;
   localparam logic [3:0] OP_MULU = 4'hC, OP_DIVU = 4'hD, OP_CMP  = 4'hE, OP_PASS = 4'hF;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             flag_z_q, flag_z_d, flag_c_q, flag_c_d;
   logic             flag_v_q, flag_v_d, flag_n_q, flag_n_d;
   logic             div_zero_q, div_zero_d;
   logic             cst_q, cst_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] a_i, b_i;
   logic [3:0]       op_i;

   assign a_i  = a ^ {WIDTH{ACTIVE_LOW_IO}};
   assign b_i  = b ^ {WIDTH{ACTIVE_LOW_IO}};
   assign op_i = opcode ^ {4{ACTIVE_LOW_IO}};

   logic [WIDTH:0]   add_x, sub_x;
   logic [WIDTH-1:0] sc_res, sc_hi;
   logic             sc_z, sc_c, sc_v, sc_n, sc_dz;

   always_comb begin
      add_x  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, (op_i == OP_ADC) & cst_q};
      sub_x  = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, (op_i == OP_SBB) & cst_q};
      sc_res = '0;
      sc_hi  = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_dz  = 1'b0;
      case (op_i)
         OP_ADD, OP_ADC: begin
            sc_res = add_x[M:0];
            sc_c   = add_x[WIDTH];
            sc_v   = (a_i[M] == b_i[M]) && (add_x[M] != a_i[M]);
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            sc_res = (op_i == OP_CMP) ? a_i : sub_x[M:0];
            sc_c   = sub_x[WIDTH];
            sc_v   = (a_i[M] != b_i[M]) && (sub_x[M] != a_i[M]);
         end
         OP_AND:  sc_res = a_i & b_i;
         OP_OR:   sc_res = a_i | b_i;
         OP_XOR:  sc_res = a_i ^ b_i;
         OP_NOT:  sc_res = ~a_i;
         OP_SHL:  begin sc_res = {a_i[M-1:0], 1'b0};   sc_c = a_i[M]; end
         OP_SHR:  begin sc_res = {1'b0, a_i[M:1]};     sc_c = a_i[0]; end
         OP_SRA:  begin sc_res = {a_i[M], a_i[M:1]};   sc_c = a_i[0]; end
         OP_ROL:  begin sc_res = {a_i[M-1:0], a_i[M]}; sc_c = a_i[M]; end
         OP_DIVU: begin sc_res = '1; sc_hi = a_i; sc_dz = 1'b1; end
         OP_PASS: sc_res = b_i;
         default: sc_res = '0;
      endcase
      // CMP reports the flags of a-b while passing a through as the result
      sc_z = (op_i == OP_CMP) ? (sub_x[M:0] == '0) : (sc_res == '0);
      sc_n = (op_i == OP_CMP) ? sub_x[M] : sc_res[M];
   end

   logic [WIDTH:0]   mul_sum, div_shift;
   logic [WIDTH+1:0] div_trial;
   logic [WIDTH-1:0] it_hi, it_lo;

   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
      div_shift = {acc_hi_q, acc_lo_q[M]};
      div_trial = {1'b0, div_shift} - {2'b00, opd_q};
      if (!is_div_q) begin
         it_hi = mul_sum[WIDTH:1];
         it_lo = {mul_sum[0], acc_lo_q[M:1]};
      end else if (div_trial[WIDTH+1]) begin
         it_hi = div_shift[M:0];
         it_lo = {acc_lo_q[M-1:0], 1'b0};
      end else begin
         it_hi = div_trial[M:0];
         it_lo = {acc_lo_q[M-1:0], 1'b1};
      end
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flag_z_d    = flag_z_q;
      flag_c_d    = flag_c_q;
      flag_v_d    = flag_v_q;
      flag_n_d    = flag_n_q;
      div_zero_d  = div_zero_q;
      cst_d       = cst_q;
      is_div_d    = is_div_q;
      opd_d       = opd_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               div_zero_d = 1'b0;
               if (op_i == OP_MULU || (op_i == OP_DIVU && b_i != '0)) begin
                  state_d  = S_CALC;
                  is_div_d = (op_i == OP_DIVU);
                  opd_d    = (op_i == OP_DIVU) ? b_i : a_i;
                  acc_lo_d = (op_i == OP_DIVU) ? a_i : b_i;
                  acc_hi_d = '0;
                  cnt_d    = '0;
               end else begin
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
                  result_d    = sc_res;
                  result_hi_d = sc_hi;
                  flag_z_d    = sc_z;
                  flag_c_d    = sc_c;
                  flag_v_d    = sc_v;
                  flag_n_d    = sc_n;
                  div_zero_d  = sc_dz;
                  cst_d       = sc_c;
               end
            end
         end
         S_CALC: begin
            acc_hi_d = it_hi;
            acc_lo_d = it_lo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               result_d    = it_lo;
               result_hi_d = it_hi;
               flag_z_d    = (it_lo == '0);
               flag_n_d    = it_lo[M];
               flag_v_d    = 1'b0;
               flag_c_d    = !is_div_q && (it_hi != '0);
               cst_d       = !is_div_q && (it_hi != '0);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         flag_z_q    <= 1'b0;
         flag_c_q    <= 1'b0;
         flag_v_q    <= 1'b0;
         flag_n_q    <= 1'b0;
         div_zero_q  <= 1'b0;
         cst_q       <= 1'b0;
         is_div_q    <= 1'b0;
         opd_q       <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flag_z_q    <= flag_z_d;
         flag_c_q    <= flag_c_d;
         flag_v_q    <= flag_v_d;
         flag_n_q    <= flag_n_d;
         div_zero_q  <= div_zero_d;
         cst_q       <= cst_d;
         is_div_q    <= is_div_d;
         opd_q       <= opd_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         cnt_q       <= cnt_d;
      end
   end

   // handshake pins stay true-polarity; data and flag pins follow ACTIVE_LOW_IO
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q ^ {WIDTH{ACTIVE_LOW_IO}};
   assign result_hi = result_hi_q ^ {WIDTH{ACTIVE_LOW_IO}};
   assign flag_z    = flag_z_q ^ ACTIVE_LOW_IO;
   assign flag_c    = flag_c_q ^ ACTIVE_LOW_IO;
   assign flag_v    = flag_v_q ^ ACTIVE_LOW_IO;
   assign flag_n    = flag_n_q ^ ACTIVE_LOW_IO;
   assign div_zero  = div_zero_q ^ ACTIVE_LOW_IO;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with true-polarity pins: each task drives one scenario
// and compares the DUT against hand-computed values.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [3:0] opcode = '0;
   logic       in_ready, out_valid, flag_z, flag_c, flag_v, flag_n, div_zero;
   logic [7:0] result, result_hi;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] r;
      logic       c;
      logic       v;
   } vec_t;

   vec_t vt [13] = '{
      '{4'h2, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0},
      '{4'h2, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0},
      '{4'h3, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0},
      '{4'h4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0},
      '{4'h5, 8'h0F, 8'h33, 8'hF0, 1'b0, 1'b0},
      '{4'h6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0},
      '{4'h7, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0},
      '{4'hA, 8'h81, 8'h00, 8'hC0, 1'b1, 1'b0},
      '{4'hB, 8'h81, 8'h00, 8'h03, 1'b1, 1'b0},
      '{4'hF, 8'h12, 8'h5A, 8'h5A, 1'b0, 1'b0},
      '{4'hE, 8'h03, 8'h05, 8'h03, 1'b1, 1'b0},
      '{4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
      '{4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1}
   };

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8), .ACTIVE_LOW_IO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .flag_z(flag_z), .flag_c(flag_c),
      .flag_v(flag_v), .flag_n(flag_n), .div_zero(div_zero)
   );

   // Waits (bounded) for in_ready, then presents one command for exactly one accepting edge.
   task automatic send(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      opcode = op; a = aa; b = bb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic take;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if ({out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n, div_zero} !== 22'h0) begin
         errors++;
         $display("FAIL reset_outputs: vld=%b res=%h hi=%h zcvn=%b%b%b%b dz=%b, required all 0",
                  out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n, div_zero);
      end
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_add_adc;
      send(4'h0, 8'hF0, 8'h20);
      checks++;
      if ({out_valid, result, result_hi} !== {1'b1, 8'h10, 8'h00}) begin
         errors++;
         $display("FAIL add_result: vld=%b res=%h hi=%h, required 1 10 00", out_valid, result, result_hi);
      end
      checks++;
      if ({flag_z, flag_c, flag_v, flag_n} !== 4'b0100) begin
         errors++;
         $display("FAIL add_flags: zcvn=%b%b%b%b, required 0100", flag_z, flag_c, flag_v, flag_n);
      end
      take();
      send(4'h8, 8'h01, 8'h01);
      checks++;
      if ({result, flag_c} !== {8'h03, 1'b0}) begin
         errors++;
         $display("FAIL adc_carry_in: res=%h c=%b, required 03 0", result, flag_c);
      end
      take();
   endtask

   task automatic test_sub_sbb;
      send(4'h1, 8'h05, 8'h07);
      checks++;
      if ({result, flag_z, flag_c, flag_v, flag_n} !== {8'hFE, 4'b0101}) begin
         errors++;
         $display("FAIL sub: res=%h zcvn=%b%b%b%b, required FE 0101", result, flag_z, flag_c, flag_v, flag_n);
      end
      take();
      send(4'h9, 8'h10, 8'h00);
      checks++;
      if ({result, flag_z, flag_c, flag_v, flag_n} !== {8'h0F, 4'b0000}) begin
         errors++;
         $display("FAIL sbb: res=%h zcvn=%b%b%b%b, required 0F 0000", result, flag_z, flag_c, flag_v, flag_n);
      end
      take();
   endtask

   task automatic test_single_ops;
      for (int i = 0; i < 13; i++) begin
         send(vt[i].op, vt[i].va, vt[i].vb);
         checks++;
         if ({out_valid, result, result_hi, flag_c, flag_v} !== {1'b1, vt[i].r, 8'h00, vt[i].c, vt[i].v}) begin
            errors++;
            $display("FAIL op%h_a%h_b%h: vld=%b res=%h hi=%h c=%b v=%b, required 1 %h 00 %b %b",
                     vt[i].op, vt[i].va, vt[i].vb, out_valid, result, result_hi, flag_c, flag_v,
                     vt[i].r, vt[i].c, vt[i].v);
         end
         if (vt[i].op != 4'hE) begin
            checks++;
            if ({flag_z, flag_n} !== {vt[i].r == 8'h00, vt[i].r[7]}) begin
               errors++;
               $display("FAIL op%h_zn: z=%b n=%b, required %b %b", vt[i].op, flag_z, flag_n,
                        vt[i].r == 8'h00, vt[i].r[7]);
            end
         end
         take();
      end
   endtask

   task automatic test_mulu;
      int cyc;
      send(4'hC, 8'h0F, 8'h11);
      cyc = 1;
      while (!out_valid && cyc < 30) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mulu_busy: in_ready=%b at cycle %0d, required 0", in_ready, cyc);
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc != 9) begin
         errors++;
         $display("FAIL mulu_latency: out_valid at cycle %0d, required 9", cyc);
      end
      checks++;
      if ({result, result_hi, flag_z, flag_c, flag_v, flag_n} !== {8'hFF, 8'h00, 4'b0001}) begin
         errors++;
         $display("FAIL mulu_0f_11: res=%h hi=%h zcvn=%b%b%b%b, required FF 00 0001",
                  result, result_hi, flag_z, flag_c, flag_v, flag_n);
      end
      take();
      send(4'hC, 8'hFF, 8'hFF);
      cyc = 1;
      while (!out_valid && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if ({out_valid, result, result_hi, flag_z, flag_c, flag_n} !== {1'b1, 8'h01, 8'hFE, 3'b010}) begin
         errors++;
         $display("FAIL mulu_ff_ff: vld=%b res=%h hi=%h z=%b c=%b n=%b, required 1 01 FE 0 1 0",
                  out_valid, result, result_hi, flag_z, flag_c, flag_n);
      end
      take();
   endtask

   task automatic test_divu;
      int cyc;
      send(4'hD, 8'h64, 8'h07);
      cyc = 1;
      while (!out_valid && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc != 9) begin
         errors++;
         $display("FAIL divu_latency: out_valid at cycle %0d, required 9", cyc);
      end
      checks++;
      if ({result, result_hi, flag_c, div_zero} !== {8'h0E, 8'h02, 2'b00}) begin
         errors++;
         $display("FAIL divu_64_07: res=%h hi=%h c=%b dz=%b, required 0E 02 0 0",
                  result, result_hi, flag_c, div_zero);
      end
      take();
      send(4'hD, 8'h2A, 8'h00);
      checks++;
      if ({out_valid, result, result_hi, div_zero, flag_c} !== {1'b1, 8'hFF, 8'h2A, 2'b10}) begin
         errors++;
         $display("FAIL divu_by_zero: vld=%b res=%h hi=%h dz=%b c=%b, required 1 FF 2A 1 0",
                  out_valid, result, result_hi, div_zero, flag_c);
      end
      take();
      send(4'h0, 8'h01, 8'h01);
      checks++;
      if ({result, div_zero} !== {8'h02, 1'b0}) begin
         errors++;
         $display("FAIL div_zero_clear: res=%h dz=%b, required 02 0", result, div_zero);
      end
      take();
   endtask

   task automatic test_backpressure;
      send(4'h0, 8'h01, 8'h02);
      for (int i = 0; i < 5; i++) begin
         opcode = 4'(i); a = 8'h40 + 8'(i); b = 8'h11 * 8'(i + 1); in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, result, flag_c} !== {2'b10, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL hold_cycle%0d: vld=%b rdy=%b res=%h c=%b, required 1 0 03 0",
                     i, out_valid, in_ready, result, flag_c);
         end
      end
      opcode = 4'h0; a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL handoff: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result} !== {1'b1, 8'h30}) begin
         errors++;
         $display("FAIL next_accept: vld=%b res=%h, required 1 30", out_valid, result);
      end
      take();
   endtask

   task automatic test_reset_mid_calc;
      send(4'h6, 8'hC0, 8'h00);
      checks++;
      if ({result, flag_c, flag_n} !== {8'h80, 2'b11}) begin
         errors++;
         $display("FAIL shl_setup: res=%h c=%b n=%b, required 80 1 1", result, flag_c, flag_n);
      end
      take();
      send(4'hC, 8'hFF, 8'hFF);
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n, div_zero} !== 22'h0) begin
         errors++;
         $display("FAIL reset_mid_calc: vld=%b res=%h hi=%h zcvn=%b%b%b%b dz=%b, required all 0",
                  out_valid, result, result_hi, flag_z, flag_c, flag_v, flag_n, div_zero);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL ready_after_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      send(4'h8, 8'h01, 8'h01);
      checks++;
      if ({out_valid, result, flag_c} !== {1'b1, 8'h02, 1'b0}) begin
         errors++;
         $display("FAIL adc_after_reset: vld=%b res=%h c=%b, required 1 02 0", out_valid, result, flag_c);
      end
      take();
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_sub_sbb();
      test_single_ops();
      test_mulu();
      test_divu();
      test_backpressure();
      test_reset_mid_calc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
